// File: rtl/fpu_mul_arbiter.sv
// Round-robin front end for one shared, fixed-latency pipelined FP32 multiplier.
// Each issued operation carries a requester tag so its product returns to the issuer.
module fpu_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SIZE_DATA   = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_a,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_b,
    output logic                           o_mul_valid,
    output logic [SIZE_DATA-1:0]           o_mul_a,
    output logic [SIZE_DATA-1:0]           o_mul_b,
    input  logic [SIZE_DATA-1:0]           i_mul_result,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    output logic [SIZE_DATA-1:0]           o_rsp_data,
    output logic                           o_busy
);

    localparam int          ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREQ_U = NUM_REQ;

    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W-1:0]        scan_id;
    logic                   grant_any;
    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        issue_id;
    logic [MUL_LATENCY-1:0] tag_valid;
    logic [ID_W-1:0]        tag_id [MUL_LATENCY];

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        scan_id   = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            scan_id = ID_W'((32'(rr_ptr) + i) % NREQ_U);
            if (!grant_any && i_req_valid[scan_id]) begin
                grant_any       = 1'b1;
                grant[scan_id]  = 1'b1;
                grant_id        = scan_id;
            end
        end
        if (i_rst) begin
            grant     = '0;
            grant_any = 1'b0;
        end
    end

    assign o_req_ready = grant;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr      <= '0;
            o_mul_valid <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            issue_id    <= '0;
        end else begin
            o_mul_valid <= grant_any;
            if (grant_any) begin
                rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                o_mul_a  <= i_req_a[grant_id*SIZE_DATA +: SIZE_DATA];
                o_mul_b  <= i_req_b[grant_id*SIZE_DATA +: SIZE_DATA];
                issue_id <= grant_id;
            end
        end
    end

    // Tags shadow the multiplier pipeline exactly; it never stalls, so neither do they.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_valid <= '0;
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= o_mul_valid;
            tag_id[0]    <= issue_id;
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= '0;
            if (tag_valid[MUL_LATENCY-1]) begin
                o_rsp_valid[tag_id[MUL_LATENCY-1]] <= 1'b1;
                o_rsp_data                         <= i_mul_result;
            end
        end
    end

    assign o_busy = o_mul_valid | (|tag_valid) | (|o_rsp_valid);

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Bench for fpu_mul_arbiter: random traffic against a cycle-indexed scoreboard
// of issued operations and a stand-in pipelined multiplier.
module tb_fpu_mul_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 3;

    typedef struct packed {
        logic [N-1:0] ready;
        logic         mv;
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        logic [N-1:0] rv;
        logic [W-1:0] rd;
        logic         busy;
    } obs_t;

    typedef struct {
        int           hs;
        int           id;
        logic [W-1:0] data;
    } op_t;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req_valid;
    logic [N-1:0]   o_req_ready;
    logic [N*W-1:0] i_req_a;
    logic [N*W-1:0] i_req_b;
    logic           o_mul_valid;
    logic [W-1:0]   o_mul_a;
    logic [W-1:0]   o_mul_b;
    logic [W-1:0]   i_mul_result;
    logic [N-1:0]   o_rsp_valid;
    logic [W-1:0]   o_rsp_data;
    logic           o_busy;

    always #5 i_clk = ~i_clk;

    fpu_mul_arbiter #(
        .NUM_REQ     (N),
        .SIZE_DATA   (W),
        .MUL_LATENCY (L)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_a      (i_req_a),
        .i_req_b      (i_req_b),
        .o_mul_valid  (o_mul_valid),
        .o_mul_a      (o_mul_a),
        .o_mul_b      (o_mul_b),
        .i_mul_result (i_mul_result),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_data   (o_rsp_data),
        .o_busy       (o_busy)
    );

    // Stand-in multiplier: exact for 2.0*3.0, otherwise a distinctive mix of the operands.
    function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h9E37_79B9;
    endfunction

    logic [W-1:0] mp [L];
    always @(posedge i_clk) begin
        mp[0] <= fmul(o_mul_a, o_mul_b);
        for (int k = 1; k < L; k++) mp[k] <= mp[k-1];
    end
    assign i_mul_result = mp[L-1];

    op_t          q[$];
    int           rr;
    int           cyc;
    logic [W-1:0] m_ma, m_mb, m_rd;
    int           vectors;
    int           miscompares;

    function automatic logic [N*W-1:0] rand_ops();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    // Drive one cycle, derive expectations from the scoreboard, sample at negedge,
    // then advance the scoreboard across the coming edge.
    task automatic tick(input logic rst, input logic [N-1:0] v,
                        input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        output obs_t exp, output obs_t obs);
        int k;
        i_rst       = rst;
        i_req_valid = v;
        i_req_a     = a;
        i_req_b     = b;
        @(negedge i_clk);
        k = -1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                int j;
                j = (rr + i) % N;
                if (k < 0 && v[j]) k = j;
            end
        end
        exp       = '0;
        if (k >= 0) exp.ready[k] = 1'b1;
        foreach (q[i]) begin
            if (q[i].hs + 1 == cyc) exp.mv = 1'b1;
            if (q[i].hs + L + 2 == cyc) begin
                exp.rv[q[i].id] = 1'b1;
                m_rd = q[i].data;
            end
            if (cyc >= q[i].hs + 1 && cyc <= q[i].hs + L + 2) exp.busy = 1'b1;
        end
        exp.ma = m_ma;
        exp.mb = m_mb;
        exp.rd = m_rd;
        obs.ready = o_req_ready;
        obs.mv    = o_mul_valid;
        obs.ma    = o_mul_a;
        obs.mb    = o_mul_b;
        obs.rv    = o_rsp_valid;
        obs.rd    = o_rsp_data;
        obs.busy  = o_busy;
        while (q.size() > 0 && q[0].hs + L + 2 <= cyc) void'(q.pop_front());
        if (rst) begin
            q.delete();
            rr   = 0;
            m_ma = '0;
            m_mb = '0;
            m_rd = '0;
        end else if (k >= 0) begin
            q.push_back('{hs: cyc, id: k, data: fmul(a[k*W +: W], b[k*W +: W])});
            rr   = (k + 1) % N;
            m_ma = a[k*W +: W];
            m_mb = b[k*W +: W];
        end
        @(posedge i_clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        i_rst       = 1'b1;
        i_req_valid = '1;
        i_req_a     = rand_ops();
        i_req_b     = rand_ops();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        o.ready = o_req_ready;
        o.mv    = o_mul_valid;
        o.ma    = o_mul_a;
        o.mb    = o_mul_b;
        o.rv    = o_rsp_valid;
        o.rd    = o_rsp_data;
        o.busy  = o_busy;
        vectors++;
        if (o !== obs_t'('0)) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", o, obs_t'('0));
        end
        @(posedge i_clk);
        #1;
        q.delete();
        rr   = 0;
        cyc  = 0;
        m_ma = '0;
        m_mb = '0;
        m_rd = '0;
    endtask

    task automatic test_single();
        obs_t e, o;
        logic [N*W-1:0] a, b;
        a = rand_ops();
        b = rand_ops();
        a[2*W +: W] = 32'h4000_0000;
        b[2*W +: W] = 32'h4040_0000;
        for (int c = 0; c < L + 5; c++) begin
            tick(1'b0, (c == 1) ? 4'b0100 : 4'b0000, a, b, e, o);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL single c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_all_four();
        obs_t e, o;
        for (int c = 0; c < 8 + L + 3; c++) begin
            tick(1'b0, (c < 8) ? 4'b1111 : 4'b0000, rand_ops(), rand_ops(), e, o);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL all_four c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_wrap_skip();
        obs_t e, o;
        logic [N-1:0] pat [7];
        pat = '{4'b0100, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b1000, 4'b0000};
        for (int c = 0; c < 7 + L + 2; c++) begin
            tick(1'b0, (c < 7) ? pat[c] : 4'b0000, rand_ops(), rand_ops(), e, o);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wrap_skip c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_sparse();
        obs_t e, o;
        logic [N-1:0] v;
        for (int c = 0; c < 36 + L + 3; c++) begin
            v = '0;
            if (c < 36 && c % 3 == 0) v[$urandom_range(0, N-1)] = 1'b1;
            tick(1'b0, v, rand_ops(), rand_ops(), e, o);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL sparse c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        logic rst;
        logic [N-1:0] v;
        for (int c = 0; c < 16; c++) begin
            rst = (c == 4);
            v   = (c < 3 || c == 4 || c == 10) ? 4'b1111 : 4'b0000;
            tick(rst, v, rand_ops(), rand_ops(), e, o);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_mid c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_idle();
        obs_t e, o;
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 4'b0000, rand_ops(), rand_ops(), e, o);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL idle c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        for (int c = 0; c < 150 + L + 3; c++) begin
            tick(1'b0, (c < 150) ? 4'($urandom) : 4'b0000, rand_ops(), rand_ops(), e, o);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL back_to_back c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_all_four();
        test_wrap_skip();
        test_sparse();
        test_reset_mid();
        test_idle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
